mc_cmd_arb_mux: RTL and testbench

Parametrised command arbiter-multiplexer for the DDR4/DDR3 memory controller. It selects one of `NUM_SLOTS` per-group command requests, using either fixed or round-robin priority with an urgent class. The winner's bank, group, logical rank, rank and row are captured into a registered output stage with a valid/ready handshake. It sits between the per-group command FSMs and the activate/precharge issue logic and supersedes the purely combinational 4-way select.

---
 rtl/mc_cmd_arb_mux_pkg.sv | 35 +++
 rtl/mc_cmd_arb_mux_if.sv | 42 ++++
 rtl/mc_cmd_arb_mux_rr_arb.sv | 30 +++
 rtl/mc_cmd_arb_mux.sv | 117 +++++++++++
 tb/tb_mc_cmd_arb_mux.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_cmd_arb_mux_pkg.sv
// rtl/mc_cmd_arb_mux_pkg.sv - shared constants and arbitration helpers
// Purpose : priority-mode constants, pointer-width helper and the rotating
//           one-hot picker used by the command arbiter.
// Ports   : none (package).
package mc_cmd_arb_pkg;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;
  localparam int MAX_SLOTS = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Scans upward from ptr with wrap at MAX_SLOTS. Request bits at or above
  // the real slot count are always zero and ptr stays below that count, so
  // wrapping at 16 lands on the same winner as wrapping at NUM_SLOTS.
  function automatic logic [MAX_SLOTS-1:0] rr_pick(input logic [MAX_SLOTS-1:0] req,
                                                   input logic [3:0]           ptr);
    logic [MAX_SLOTS-1:0] gnt;
    logic [3:0]           idx;
    logic                 found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mc_cmd_arb_mux_if.sv
// rtl/mc_cmd_arb_mux_if.sv - request/winner bundle for the command arbiter-mux
// Purpose : groups per-slot requests, packed per-slot fields and the winner
//           output stage handshake.
// Ports   : slave  - arbiter view (requests in, grant/winner out)
//           master - requester/consumer view (mirror of slave)
interface mc_cmd_arb_mux_if #(
  parameter int NUM_SLOTS = 4,
  parameter int ABITS     = 18,
  parameter int RKBITS    = 2,
  parameter int LR_WIDTH  = 1,
  parameter int BABITS    = 2,
  parameter int BGBITS    = 2
);

  logic [NUM_SLOTS-1:0]          cmdReq;
  logic [NUM_SLOTS-1:0]          cmdUrgent;
  logic [NUM_SLOTS*BABITS-1:0]   cmdBank;
  logic [NUM_SLOTS*BGBITS-1:0]   cmdGroup;
  logic [NUM_SLOTS*LR_WIDTH-1:0] cmdLRank;
  logic [NUM_SLOTS*RKBITS-1:0]   cmdRank;
  logic [NUM_SLOTS*ABITS-1:0]    cmdRow;
  logic [NUM_SLOTS-1:0]          cmdGnt;
  logic                          winValid;
  logic                          winReady;
  logic [NUM_SLOTS-1:0]          winSel;
  logic [BABITS-1:0]             winBank;
  logic [BGBITS-1:0]             winGroup;
  logic [LR_WIDTH-1:0]           winLRank;
  logic [RKBITS-1:0]             winRank;
  logic [ABITS-1:0]              winRow;

  modport slave (
    input  cmdReq, cmdUrgent, cmdBank, cmdGroup, cmdLRank, cmdRank, cmdRow, winReady,
    output cmdGnt, winValid, winSel, winBank, winGroup, winLRank, winRank, winRow
  );

  modport master (
    output cmdReq, cmdUrgent, cmdBank, cmdGroup, cmdLRank, cmdRank, cmdRow, winReady,
    input  cmdGnt, winValid, winSel, winBank, winGroup, winLRank, winRank, winRow
  );

endinterface

// File: rtl/mc_cmd_arb_mux_rr_arb.sv
// rtl/mc_cmd_arb_mux_rr_arb.sv - one-hot fixed/round-robin picker
// Purpose : picks one requesting slot, lowest index in fixed mode or first
//           at/after ptr in round-robin mode.
// Ports   : req (in) request vector, ptr (in) search start, rr_mode (in)
//           1 = round-robin, gnt (out) one-hot winner, zero if no request.
module mc_rr_arb
  import mc_cmd_arb_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int PTR_W     = clog2_min1(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic [NUM_SLOTS-1:0] gnt
);

  logic [MAX_SLOTS-1:0] req_ext;
  logic [MAX_SLOTS-1:0] gnt_ext;
  logic [3:0]           start;

  always_comb begin
    req_ext = MAX_SLOTS'(req);
    // Fixed priority is round-robin frozen at slot 0.
    start   = rr_mode ? 4'(ptr) : 4'd0;
    gnt_ext = rr_pick(req_ext, start);
    gnt     = NUM_SLOTS'(gnt_ext);
  end

endmodule

// File: rtl/mc_cmd_arb_mux.sv
// rtl/mc_cmd_arb_mux.sv - command arbiter with registered winner stage
// Purpose : picks one slot per cycle (urgent class first), captures its
//           bank/group/lrank/rank/row into a valid/ready output register.
// Ports   : clk, rst_n (async active-low), bus (slave modport): per-slot
//           requests and fields in, cmdGnt pulse and winner stage out.
module mc_cmd_arb_mux
  import mc_cmd_arb_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ABITS     = 18,
  parameter int RKBITS    = 2,
  parameter int LR_WIDTH  = 1,
  parameter int BABITS    = 2,
  parameter int BGBITS    = 2,
  parameter int PRI_MODE  = PRI_RR
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_cmd_arb_mux_if.slave bus
);

  localparam int PTR_W = clog2_min1(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] urg_req;
  logic [NUM_SLOTS-1:0] act_req;
  logic [NUM_SLOTS-1:0] gnt;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [PTR_W-1:0]     win_idx;
  logic                 load;

  logic [BABITS-1:0]    bank_mux;
  logic [BGBITS-1:0]    group_mux;
  logic [LR_WIDTH-1:0]  lrank_mux;
  logic [RKBITS-1:0]    rank_mux;
  logic [ABITS-1:0]     row_mux;

  logic                 win_valid;
  logic [NUM_SLOTS-1:0] win_sel;
  logic [BABITS-1:0]    win_bank;
  logic [BGBITS-1:0]    win_group;
  logic [LR_WIDTH-1:0]  win_lrank;
  logic [RKBITS-1:0]    win_rank;
  logic [ABITS-1:0]     win_row;

  // Urgent requests, when present, shut out every normal request.
  always_comb begin
    urg_req = bus.cmdReq & bus.cmdUrgent;
    act_req = (|urg_req) ? urg_req : bus.cmdReq;
  end

  mc_rr_arb #(
    .NUM_SLOTS (NUM_SLOTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req     (act_req),
    .ptr     (ptr),
    .rr_mode (PRI_MODE == PRI_RR),
    .gnt     (gnt)
  );

  assign load = !win_valid || bus.winReady;

  // AND-OR select over the one-hot grant; also recovers the winner index.
  always_comb begin
    bank_mux  = '0;
    group_mux = '0;
    lrank_mux = '0;
    rank_mux  = '0;
    row_mux   = '0;
    win_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      bank_mux  |= bus.cmdBank [i*BABITS   +: BABITS]   & {BABITS{gnt[i]}};
      group_mux |= bus.cmdGroup[i*BGBITS   +: BGBITS]   & {BGBITS{gnt[i]}};
      lrank_mux |= bus.cmdLRank[i*LR_WIDTH +: LR_WIDTH] & {LR_WIDTH{gnt[i]}};
      rank_mux  |= bus.cmdRank [i*RKBITS   +: RKBITS]   & {RKBITS{gnt[i]}};
      row_mux   |= bus.cmdRow  [i*ABITS    +: ABITS]    & {ABITS{gnt[i]}};
      win_idx   |= gnt[i] ? PTR_W'(i) : '0;
    end
    ptr_nxt = (win_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_sel   <= '0;
      win_bank  <= '0;
      win_group <= '0;
      win_lrank <= '0;
      win_rank  <= '0;
      win_row   <= '0;
      ptr       <= '0;
    end else if (load) begin
      win_valid <= |gnt;
      if (|gnt) begin
        win_sel   <= gnt;
        win_bank  <= bank_mux;
        win_group <= group_mux;
        win_lrank <= lrank_mux;
        win_rank  <= rank_mux;
        win_row   <= row_mux;
        ptr       <= ptr_nxt;
      end
    end
  end

  // Gated by rst_n so no grant leaks out while the stage is held in reset.
  assign bus.cmdGnt   = (rst_n && load) ? gnt : '0;
  assign bus.winValid = win_valid;
  assign bus.winSel   = win_sel;
  assign bus.winBank  = win_bank;
  assign bus.winGroup = win_group;
  assign bus.winLRank = win_lrank;
  assign bus.winRank  = win_rank;
  assign bus.winRow   = win_row;

endmodule

// File: tb/tb_mc_cmd_arb_mux.sv
// tb/tb_mc_cmd_arb_mux.sv - bench for the command arbiter-mux
// Purpose : drives a 4-slot round-robin and a 5-slot fixed-priority instance
//           and checks them against a slot-level reference model.
// Ports   : none (top-level bench).
module tb_mc_cmd_arb_mux;
  import mc_cmd_arb_pkg::*;

  localparam int NA = 4;
  localparam int NB = 5;
  localparam int AW = 18;
  localparam int RW = 2;
  localparam int LW = 1;
  localparam int BW = 2;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_cmd_arb_mux_if #(.NUM_SLOTS(NA), .ABITS(AW), .RKBITS(RW), .LR_WIDTH(LW),
                      .BABITS(BW), .BGBITS(GW)) ifa ();
  mc_cmd_arb_mux_if #(.NUM_SLOTS(NB), .ABITS(AW), .RKBITS(RW), .LR_WIDTH(LW),
                      .BABITS(BW), .BGBITS(GW)) ifb ();

  mc_cmd_arb_mux #(.NUM_SLOTS(NA), .ABITS(AW), .RKBITS(RW), .LR_WIDTH(LW),
                   .BABITS(BW), .BGBITS(GW), .PRI_MODE(PRI_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  mc_cmd_arb_mux #(.NUM_SLOTS(NB), .ABITS(AW), .RKBITS(RW), .LR_WIDTH(LW),
                   .BABITS(BW), .BGBITS(GW), .PRI_MODE(PRI_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  // Stimulus per instance (0 = round-robin, 1 = fixed).
  logic [15:0]   req_in [2];
  logic [15:0]   urg_in [2];
  logic          rdy_in [2];
  logic [AW-1:0] row_in   [2][16];
  logic [BW-1:0] bank_in  [2][16];
  logic [GW-1:0] group_in [2][16];
  logic [LW-1:0] lrank_in [2][16];
  logic [RW-1:0] rank_in  [2][16];

  // Reference model state.
  logic          m_valid [2];
  logic [15:0]   m_sel   [2];
  int            m_ptr   [2];
  logic [AW-1:0] m_row   [2];
  logic [BW-1:0] m_bank  [2];
  logic [GW-1:0] m_group [2];
  logic [LW-1:0] m_lrank [2];
  logic [RW-1:0] m_rank  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply();
    ifa.cmdReq    = req_in[0][NA-1:0];
    ifa.cmdUrgent = urg_in[0][NA-1:0];
    ifa.winReady  = rdy_in[0];
    for (int i = 0; i < NA; i++) begin
      ifa.cmdRow  [i*AW +: AW] = row_in[0][i];
      ifa.cmdBank [i*BW +: BW] = bank_in[0][i];
      ifa.cmdGroup[i*GW +: GW] = group_in[0][i];
      ifa.cmdLRank[i*LW +: LW] = lrank_in[0][i];
      ifa.cmdRank [i*RW +: RW] = rank_in[0][i];
    end
    ifb.cmdReq    = req_in[1][NB-1:0];
    ifb.cmdUrgent = urg_in[1][NB-1:0];
    ifb.winReady  = rdy_in[1];
    for (int i = 0; i < NB; i++) begin
      ifb.cmdRow  [i*AW +: AW] = row_in[1][i];
      ifb.cmdBank [i*BW +: BW] = bank_in[1][i];
      ifb.cmdGroup[i*GW +: GW] = group_in[1][i];
      ifb.cmdLRank[i*LW +: LW] = lrank_in[1][i];
      ifb.cmdRank [i*RW +: RW] = rank_in[1][i];
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_sel[d] = '0; m_ptr[d] = 0;
      m_row[d] = '0; m_bank[d] = '0; m_group[d] = '0; m_lrank[d] = '0; m_rank[d] = '0;
    end
  endtask

  // Winner from the rules: urgent set if non-empty, else all requests;
  // fixed = smallest slot number, round-robin = first slot met walking
  // ptr, ptr+1, ... modulo the slot count.
  function automatic int model_pick(input logic [15:0] req, input logic [15:0] urg,
                                    input int ptr, input int n, input bit rr);
    logic [15:0] pool;
    int s;
    pool = ((req & urg) != 16'd0) ? (req & urg) : req;
    for (int k = 0; k < n; k++) begin
      s = rr ? (ptr + k) % n : k;
      if (pool[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_check(input int d);
    int n; bit rr; int w; bit load;
    string t;
    logic [15:0] a_gnt, a_sel, e_gnt;
    logic a_valid;
    logic [31:0] a_row, a_bank, a_group, a_lrank, a_rank;
    n  = (d == 0) ? NA : NB;
    rr = (d == 0);
    t  = (d == 0) ? "rr" : "fx";
    if (d == 0) begin
      a_gnt = 16'(ifa.cmdGnt); a_sel = 16'(ifa.winSel); a_valid = ifa.winValid;
      a_row = 32'(ifa.winRow); a_bank = 32'(ifa.winBank); a_group = 32'(ifa.winGroup);
      a_lrank = 32'(ifa.winLRank); a_rank = 32'(ifa.winRank);
    end else begin
      a_gnt = 16'(ifb.cmdGnt); a_sel = 16'(ifb.winSel); a_valid = ifb.winValid;
      a_row = 32'(ifb.winRow); a_bank = 32'(ifb.winBank); a_group = 32'(ifb.winGroup);
      a_lrank = 32'(ifb.winLRank); a_rank = 32'(ifb.winRank);
    end
    w     = model_pick(req_in[d], urg_in[d], m_ptr[d], n, rr);
    load  = rst_n && (!m_valid[d] || rdy_in[d]);
    e_gnt = (load && w >= 0) ? (16'd1 << w) : 16'd0;
    chk({t, ".gnt"},   32'(a_gnt),   32'(e_gnt));
    chk({t, ".valid"}, 32'(a_valid), 32'(m_valid[d]));
    chk({t, ".sel"},   32'(a_sel),   32'(m_sel[d]));
    chk({t, ".row"},   a_row,   32'(m_row[d]));
    chk({t, ".bank"},  a_bank,  32'(m_bank[d]));
    chk({t, ".group"}, a_group, 32'(m_group[d]));
    chk({t, ".lrank"}, a_lrank, 32'(m_lrank[d]));
    chk({t, ".rank"},  a_rank,  32'(m_rank[d]));
    if (load) begin
      if (w >= 0) begin
        m_valid[d] = 1'b1;
        m_sel[d]   = 16'd1 << w;
        m_row[d]   = row_in[d][w];
        m_bank[d]  = bank_in[d][w];
        m_group[d] = group_in[d][w];
        m_lrank[d] = lrank_in[d][w];
        m_rank[d]  = rank_in[d][w];
        if (rr) m_ptr[d] = (w + 1) % n;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  // Compare point: falling edge, inputs stable since just after the rising edge.
  task automatic step();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_in[d] = '0; urg_in[d] = '0; rdy_in[d] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        row_in[d][i] = AW'(18'h100 + i); bank_in[d][i] = BW'(i); group_in[d][i] = GW'(i + 1);
        lrank_in[d][i] = LW'(i); rank_in[d][i] = RW'(i + 2);
      end
    end
    apply();
    reset_model();

    repeat (3) begin
      step();
      chk("reset.valid", 32'(ifa.winValid), 32'd0);
      chk("reset.gnt",   32'(ifa.cmdGnt),   32'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Idle after reset.
    repeat (3) begin
      next(); apply(); step();
      chk("idle.valid", 32'(ifa.winValid), 32'd0);
      chk("idle.sel",   32'(ifa.winSel),   32'd0);
      chk("idle.row",   32'(ifa.winRow),   32'd0);
    end

    // Round-robin sweep with all four slots requesting.
    next(); req_in[0] = 16'hF; rdy_in[0] = 1'b1; apply();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr.seq_gnt", 32'(ifa.cmdGnt), 32'd1 << (k % 4));
      if (k > 0) chk("rr.seq_sel", 32'(ifa.winSel), 32'd1 << ((k - 1) % 4));
      if (k < 5) next();
    end

    // Urgent slot 2 monopolises, then slot 3 follows.
    next(); urg_in[0] = 16'h4; apply();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("urg.gnt", 32'(ifa.cmdGnt), 32'h4);
      next();
    end
    urg_in[0] = '0; apply(); step();
    chk("urg.drop_gnt", 32'(ifa.cmdGnt), 32'h8);

    // Backpressure hold.
    next(); req_in[0] = 16'h2; row_in[0][1] = 18'h155; apply(); step();
    chk("bp.gnt", 32'(ifa.cmdGnt), 32'h2);
    next(); req_in[0] = 16'h8; rdy_in[0] = 1'b0; apply();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp.hold_gnt", 32'(ifa.cmdGnt), 32'h0);
      chk("bp.hold_row", 32'(ifa.winRow), 32'h155);
      chk("bp.hold_sel", 32'(ifa.winSel), 32'h2);
      if (k < 4) next();
    end
    next(); rdy_in[0] = 1'b1; apply(); step();
    chk("bp.release_gnt", 32'(ifa.cmdGnt), 32'h8);
    next(); step();
    chk("bp.release_sel", 32'(ifa.winSel), 32'h8);

    // Fixed priority, five slots.
    next(); req_in[1] = 16'b10110; rdy_in[1] = 1'b1; apply(); step();
    chk("fx.gnt1", 32'(ifb.cmdGnt), 32'b00010);
    next(); req_in[1] = 16'b10100; apply(); step();
    chk("fx.gnt2", 32'(ifb.cmdGnt), 32'b00100);
    chk("fx.sel1", 32'(ifb.winSel), 32'b00010);
    next(); req_in[1] = 16'b10000; apply(); step();
    chk("fx.gnt4", 32'(ifb.cmdGnt), 32'b10000);
    chk("fx.sel2", 32'(ifb.winSel), 32'b00100);
    next(); req_in[1] = '0; apply(); step();
    chk("fx.sel4", 32'(ifb.winSel), 32'b10000);
    next(); step();
    chk("fx.idle_valid", 32'(ifb.winValid), 32'd0);

    // Asynchronous reset while a command is stalled.
    next(); req_in[0] = 16'h4; rdy_in[0] = 1'b1; apply(); step();
    chk("arst.load_gnt", 32'(ifa.cmdGnt), 32'h4);
    next(); req_in[0] = '0; rdy_in[0] = 1'b0; apply(); step();
    chk("arst.pre_valid", 32'(ifa.winValid), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    reset_model();
    req_in[0] = 16'hF; apply();
    #1;
    chk("arst.valid", 32'(ifa.winValid), 32'd0);
    chk("arst.sel",   32'(ifa.winSel),   32'd0);
    chk("arst.row",   32'(ifa.winRow),   32'd0);
    chk("arst.gnt",   32'(ifa.cmdGnt),   32'd0);
    step();
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("arst.first_gnt", 32'(ifa.cmdGnt), 32'h1);

    // Randomised traffic on both instances.
    for (int c = 0; c < 2500; c++) begin
      next();
      for (int d = 0; d < 2; d++) begin
        req_in[d] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom) & ((d == 0) ? 16'hF : 16'h1F);
        urg_in[d] = ($urandom_range(0, 2) == 0) ? 16'($urandom) & ((d == 0) ? 16'hF : 16'h1F) : 16'd0;
        rdy_in[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 16; i++) begin
          row_in[d][i] = AW'($urandom); bank_in[d][i] = BW'($urandom);
          group_in[d][i] = GW'($urandom); lrank_in[d][i] = LW'($urandom);
          rank_in[d][i] = RW'($urandom);
        end
      end
      apply();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
